// File: rtl/alu_result_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_tx_if
//  Description : Handshake and serial-line bundle between an ALU result
//                source and the alu_result_tx UART reporter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_result_tx_if;
  logic       start;   // level request, acted on only when the reporter is idle
  logic [7:0] result;  // ALU result to report
  logic       tx;      // UART serial line, 8N1, idle high
  logic       busy;    // report frame in progress
  logic       done;    // one-cycle pulse at frame completion

  // Source side: drives the request and result, observes status and line
  modport master (
    output start,
    output result,
    input  tx,
    input  busy,
    input  done
  );

  // Reporter side
  modport slave (
    input  start,
    input  result,
    output tx,
    output busy,
    output done
  );
endinterface
`default_nettype wire

// File: rtl/alu_result_tx.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_tx
//  Description : Reports an 8-bit ALU result over a UART line as a 4-character
//                frame: two uppercase ASCII hex digits followed by CR LF.
//                Each character is 8N1, CLKS_PER_BIT clocks per bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_result_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic             clk,
  input  logic             reset_n,
  alu_result_tx_if.slave   bus
);

  localparam logic [15:0] c_BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [1:0]  c_CHAR_LAST = 2'd3;
  localparam logic [2:0]  c_BIT_LAST  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START_BIT = 2'd1,
    S_DATA_BITS = 2'd2,
    S_STOP_BIT  = 2'd3
  } state_t;

  state_t      r_state,    w_state_nxt;
  logic [15:0] r_baud_cnt, w_baud_cnt_nxt;
  logic [2:0]  r_bit_idx,  w_bit_idx_nxt;
  logic [1:0]  r_char_idx, w_char_idx_nxt;
  logic [7:0]  r_data,     w_data_nxt;
  logic        r_tx,       w_tx_nxt;
  logic        r_done,     w_done_nxt;

  logic        w_last_baud;
  logic [7:0]  w_char;

  // Uppercase ASCII hex digit: 0-9 -> '0'-'9', A-F -> 'A'-'F'
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    hex_ascii = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  assign w_last_baud = (r_baud_cnt == c_BAUD_LAST);

  // Character currently being serialised, selected from the captured result
  always_comb begin
    w_char = 8'h0A;
    case (r_char_idx)
      2'd0:    w_char = hex_ascii(r_data[7:4]);
      2'd1:    w_char = hex_ascii(r_data[3:0]);
      2'd2:    w_char = 8'h0D;
      default: w_char = 8'h0A;
    endcase
  end

  // Next-state and next-output logic; tx and done are registered from these
  always_comb begin
    w_state_nxt    = r_state;
    w_bit_idx_nxt  = r_bit_idx;
    w_char_idx_nxt = r_char_idx;
    w_data_nxt     = r_data;
    w_tx_nxt       = r_tx;
    w_done_nxt     = 1'b0;
    w_baud_cnt_nxt = (r_state == S_IDLE || w_last_baud) ? 16'd0 : r_baud_cnt + 16'd1;

    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (bus.start) begin
          // Capture here so later result changes cannot disturb the frame
          w_data_nxt     = bus.result;
          w_state_nxt    = S_START_BIT;
          w_tx_nxt       = 1'b0;
          w_bit_idx_nxt  = 3'd0;
          w_char_idx_nxt = 2'd0;
        end
      end
      S_START_BIT: begin
        if (w_last_baud) begin
          w_state_nxt   = S_DATA_BITS;
          w_bit_idx_nxt = 3'd0;
          w_tx_nxt      = w_char[0];
        end
      end
      S_DATA_BITS: begin
        if (w_last_baud) begin
          if (r_bit_idx == c_BIT_LAST) begin
            w_state_nxt   = S_STOP_BIT;
            w_bit_idx_nxt = 3'd0;
            w_tx_nxt      = 1'b1;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_tx_nxt      = w_char[r_bit_idx + 3'd1];
          end
        end
      end
      S_STOP_BIT: begin
        if (w_last_baud) begin
          if (r_char_idx == c_CHAR_LAST) begin
            w_state_nxt    = S_IDLE;
            w_char_idx_nxt = 2'd0;
            w_tx_nxt       = 1'b1;
            w_done_nxt     = 1'b1;
          end else begin
            // Next character follows immediately with its start bit
            w_state_nxt    = S_START_BIT;
            w_char_idx_nxt = r_char_idx + 2'd1;
            w_tx_nxt       = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  // State register; asynchronous reset aborts any frame with the line idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= 16'd0;
      r_bit_idx  <= 3'd0;
      r_char_idx <= 2'd0;
      r_data     <= 8'd0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_char_idx <= w_char_idx_nxt;
      r_data     <= w_data_nxt;
      r_tx       <= w_tx_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign bus.tx   = r_tx;
  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = r_done;

endmodule
`default_nettype wire

// File: doc/alu_result_tx.md
ALU_RESULT_TX -- requirements
Module: alu_result_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, SHALL set clock cycles per UART bit (legal range 2..65535).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL request transmission of the current result; it is a level sampled each clock, acted on only when idle.
REQ-005 result  input  8  SHALL carry the 8-bit ALU result to report.
REQ-006 tx  output  1  SHALL be the UART serial line (8N1, idle high).
REQ-007 busy  output  1  SHALL be high while a report frame is in progress.
REQ-008 done  output  1  SHALL be a one-cycle pulse marking frame completion.

Function
REQ-009 A report frame SHALL be 4 characters in order: ASCII hex of result[7:4], ASCII hex of result[3:0], 0x0D, 0x0A.
REQ-010 Hex encoding SHALL map 0-9 to 0x30-0x39 and A-F to 0x41-0x46 (uppercase only).
REQ-011 Each character SHALL be sent as start bit (0), 8 data bits LSB first, stop bit (1), with each bit exactly CLKS_PER_BIT cycles.
REQ-012 Characters SHALL be sent back-to-back with no idle gap; the frame SHALL last exactly 40*CLKS_PER_BIT cycles.
REQ-013 FSM states SHALL be IDLE, START_BIT, DATA_BITS, STOP_BIT; IDLE->START_BIT on start; START_BIT->DATA_BITS after one bit time; DATA_BITS->STOP_BIT after 8th bit; STOP_BIT->START_BIT if characters remain, else ->IDLE.
REQ-014 On the rising edge where start=1 and state=IDLE, the block SHALL capture result into an internal register, set busy=1 and drive tx=0 from that edge.
REQ-015 Changes on result after capture SHALL NOT affect the frame in progress.
REQ-016 start asserted while busy=1 SHALL be ignored without queuing.
REQ-017 On completion of the final stop bit the block SHALL return to IDLE, drop busy and pulse done=1 for exactly one cycle in that same cycle.
REQ-018 start=1 in the done cycle SHALL be accepted, beginning a new frame on that edge (back-to-back frames, no gap).
REQ-019 start held high continuously SHALL produce continuous back-to-back frames, each capturing result at its own start edge.
REQ-020 tx SHALL be register-driven (glitch-free); busy SHALL be 1 in every cycle from capture edge until the done cycle, exclusive.
REQ-021 Baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap; bit index 0..7 and character index 0..3 SHALL wrap to 0 on frame end.

Reset
REQ-022 While reset_n=0: tx=1, busy=0, done=0, state=IDLE, all counters and captured result =0, independent of clk.
REQ-023 Reset asserted mid-frame SHALL abort immediately (tx high at once); no done pulse SHALL follow.
REQ-024 First start after reset_n deasserts SHALL be accepted on the first rising edge where reset_n=1 and start=1.

Verification (CLKS_PER_BIT=4)
REQ-025 result=0x3C, start pulse 1 cycle -> tx bytes 0x33,0x43,0x0D,0x0A; busy high 160 cycles; done single pulse at cycle 160 after start edge.
REQ-026 result=0x00 then 0xFF frames -> bytes 0x30,0x30,0x0D,0x0A then 0x46,0x46,0x0D,0x0A; hex digit A-F boundary checked with 0x9A -> 0x39,0x41.
REQ-027 start pulsed at cycles 10 and 80 of a frame, result changed to 0x55 mid-frame -> no extra frame; frame contents unchanged from captured value.
REQ-028 start held high for 2 frames, result=0x12 then 0x34 switched during frame 1 -> frame 2 starts in done cycle with zero gap, sends 0x33,0x34,0x0D,0x0A.
REQ-029 reset_n=0 asynchronously at cycle 57 of a frame -> tx=1, busy=0 before next clock edge; no done pulse; next start sends a complete correct frame.
